imem_loader: RTL and testbench

- Writer side of the byte-wide instruction memory that the fetch path reads (one byte per address, 1024 entries by default).
- Accepts a framed byte stream over a valid/ready handshake, e.g. from a UART receiver or a bench driver.
- Decodes the frame header and writes the payload bytes into consecutive memory addresses.
- Checks an additive checksum and reports done/err, so the core can be released from reset only after a good load.

---
 rtl/imem_loader.sv | 111 +++++++++++
 tb/tb_imem_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory writer: parses a framed byte stream (sync, address, length, payload,
// checksum) and writes the payload bytes into consecutive memory addresses.
module imem_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              abort,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    StIdle, StHdrAh, StHdrAl, StHdrLh, StHdrLl, StData, StCsum, StFin
  } state_e;

  state_e r_state, w_state_next;

  logic              w_accept;
  logic [15:0]       w_hdr16;
  logic [7:0]        r_hi;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_count;
  logic [7:0]        r_sum;
  logic              r_csum_ok;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [7:0]        r_wdata;

  assign w_accept = in_valid & in_ready;
  // r_hi holds the high byte of whichever 16-bit header field is being assembled
  assign w_hdr16  = {r_hi, in_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (abort) begin
      w_state_next = StIdle;
    end else begin
      case (r_state)
        StIdle:  if (w_accept && in_data == SYNC_BYTE) w_state_next = StHdrAh;
        StHdrAh: if (w_accept) w_state_next = StHdrAl;
        StHdrAl: if (w_accept) w_state_next = StHdrLh;
        StHdrLh: if (w_accept) w_state_next = StHdrLl;
        StHdrLl: if (w_accept) w_state_next = (w_hdr16 == 16'd0) ? StCsum : StData;
        StData:  if (w_accept && r_count == 16'd1) w_state_next = StCsum;
        StCsum:  if (w_accept) w_state_next = StFin;
        StFin:   w_state_next = StIdle;
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_comb begin
    in_ready = (r_state != StFin);
    busy     = (r_state != StIdle);
    done     = (r_state == StFin) &&  r_csum_ok;
    err      = (r_state == StFin) && !r_csum_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi      <= 8'd0;
      r_addr    <= '0;
      r_count   <= 16'd0;
      r_sum     <= 8'd0;
      r_csum_ok <= 1'b0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= 8'd0;
    end else begin
      r_we <= 1'b0;
      if (w_accept && !abort) begin
        case (r_state)
          StIdle:  r_sum   <= 8'd0;
          StHdrAh: r_hi    <= in_data;
          StHdrAl: r_addr  <= w_hdr16[ADDR_W-1:0];
          StHdrLh: r_hi    <= in_data;
          StHdrLl: r_count <= w_hdr16;
          StData: begin
            r_we    <= 1'b1;
            r_waddr <= r_addr;
            r_wdata <= in_data;
            r_addr  <= r_addr + ADDR_W'(1);
            r_count <= r_count - 16'd1;
            r_sum   <= r_sum + in_data;
          end
          StCsum:  r_csum_ok <= (in_data == r_sum);
          default: ;
        endcase
      end
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_waddr;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: frames are built from address/payload and the
// expected writes and done/err result are queued; a negedge monitor checks what the DUT emits.
module tb_imem_loader;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst, in_valid, abort, in_ready;
  logic [7:0]    in_data;
  logic          mem_we, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int         exp_addr[$];
  logic [7:0] exp_data[$];
  bit         exp_res[$];
  int         wr_cyc[$];

  int         m_a;
  logic [7:0] m_d;
  bit         m_r;

  imem_loader #(.ADDR_W(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .abort(abort), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or a frame result.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        wr_cyc.push_back(cyc);
        if (exp_addr.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          m_a = exp_addr.pop_front();
          m_d = exp_data.pop_front();
          chk("wr_addr", 32'(mem_addr), m_a);
          chk("wr_data", 32'(mem_wdata), 32'(m_d));
        end
      end
      if (done || err) begin
        chk("done_err_excl", 32'(done && err), 0);
        chk("fin_ready_low", 32'(in_ready), 0);
        chk("fin_busy", 32'(busy), 1);
        if (exp_res.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          m_r = exp_res.pop_front();
          chk("result_done", 32'(done), 32'(m_r));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit ab);
    int t;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    abort    = ab;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    abort    = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_frame(input logic [15:0] addr, input bq_t p, input bit bad,
                            input int maxgap);
    logic [7:0] sum;
    logic [7:0] cs;
    logic [15:0] len;
    bq_t fr;
    sum = 8'd0;
    len = 16'(p.size());
    foreach (p[i]) begin
      sum = sum + p[i];
      exp_addr.push_back((int'(addr) + i) % DEPTH);
      exp_data.push_back(p[i]);
    end
    cs = bad ? sum + 8'($urandom_range(1, 255)) : sum;
    exp_res.push_back(!bad);
    fr = '{8'hA5, addr[15:8], addr[7:0], len[15:8], len[7:0]};
    foreach (p[i]) fr.push_back(p[i]);
    fr.push_back(cs);
    foreach (fr[i]) begin
      send_byte(fr[i], 1'b0);
      if (maxgap > 0) repeat ($urandom_range(1, maxgap)) @(posedge clk);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_we"}, 32'(mem_we), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t p;
    logic [15:0] a;
    logic [7:0] g;
    rst = 1'b1; in_valid = 1'b0; abort = 1'b0; in_data = 8'd0;
    #1;
    check_idle_outputs("reset");
    chk("reset_addr", 32'(mem_addr), 0);
    chk("reset_wdata", 32'(mem_wdata), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Good frame, no gaps: writes must be on consecutive cycles and busy must span FIN.
    wr_cyc.delete();
    send_frame(16'h0010, '{8'h11, 8'h22, 8'h33}, 1'b0, 0);
    chk("fin_busy_direct", 32'(busy), 1);
    chk("fin_ready_direct", 32'(in_ready), 0);
    @(posedge clk); #1;
    chk("post_fin_busy", 32'(busy), 0);
    chk("post_fin_ready", 32'(in_ready), 1);
    chk("b2b_count", wr_cyc.size(), 3);
    if (wr_cyc.size() == 3) begin
      chk("b2b_gap1", wr_cyc[1] - wr_cyc[0], 1);
      chk("b2b_gap2", wr_cyc[2] - wr_cyc[1], 1);
    end

    send_frame(16'h0010, '{8'h11, 8'h22, 8'h33}, 1'b1, 0);
    send_frame(16'h03FF, '{8'hAA, 8'hBB}, 1'b0, 0);
    p.delete();
    send_frame(16'h0000, p, 1'b0, 0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_frame(16'h0020, '{8'hA5}, 1'b0, 0);
    send_frame(16'h0010, '{8'h11, 8'h22, 8'h33}, 1'b0, 5);

    // Reset after the 2nd payload byte's write has been presented.
    exp_addr.push_back(32'h100); exp_data.push_back(8'h01);
    exp_addr.push_back(32'h101); exp_data.push_back(8'h02);
    p = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h04, 8'h01, 8'h02};
    foreach (p[i]) send_byte(p[i], 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    chk("midrst_addr", 32'(mem_addr), 0);
    chk("midrst_wdata", 32'(mem_wdata), 0);
    @(negedge clk);
    rst = 1'b0;
    send_frame(16'h0040, '{8'h5A, 8'hC3}, 1'b0, 0);

    // Abort in the cycle the 2nd payload byte is accepted: that byte is never written.
    exp_addr.push_back(32'h200); exp_data.push_back(8'h0A);
    p = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h03, 8'h0A};
    foreach (p[i]) send_byte(p[i], 1'b0);
    send_byte(8'h0B, 1'b1);
    check_idle_outputs("abort");
    send_frame(16'h0050, '{8'h01, 8'hFE, 8'h80}, 1'b0, 0);

    // Randomized frames with garbage prefixes, random checksums and gaps.
    for (int f = 0; f < 25; f++) begin
      repeat ($urandom_range(0, 2)) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h00;
        send_byte(g, 1'b0);
      end
      a = 16'($urandom);
      p.delete();
      repeat ($urandom_range(0, 8)) p.push_back(8'($urandom));
      send_frame(a, p, ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    end

    // Length beyond memory depth wraps and overwrites.
    p.delete();
    repeat (DEPTH + 6) p.push_back(8'($urandom));
    send_frame(16'h0100, p, 1'b0, 0);

    repeat (5) @(posedge clk);
    chk("writes_left", exp_addr.size(), 0);
    chk("results_left", exp_res.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
